// File: rtl/encoder83_scan.sv
//==============================================================================
// Module      : encoder83_scan
// Description : Sequential 8:3 encoder. Accepts a request vector over a
//               valid/ready handshake and emits the binary index of every set
//               bit, one beat per cycle, on a valid/ready output stream.
//               Optional macro ENCODER83_MSB_FIRST_EN selects highest-bit-first
//               scan order; when undefined the scan runs lowest bit first.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module encoder83_scan #(
    parameter int WIDTH  = 8,
    parameter int CODE_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out,
    output logic              out_last,
    output logic [CODE_W:0]   remaining,
    output logic              zero_drop
);

    // Index width must exactly cover the vector width.
    generate
        if ((2 ** CODE_W) != WIDTH) begin : g_bad_params
            $error("encoder83_scan: 2**CODE_W must equal WIDTH");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pend_q, pend_d;
    logic               zero_drop_q, zero_drop_d;

    logic [CODE_W-1:0]  sel_idx;
    logic [WIDTH-1:0]   sel_mask;
    logic [CODE_W:0]    pop_cnt;
    logic               accept;
    logic               beat;

    // Pick the next index to emit from the pending bits; last match wins.
    always_comb begin
        sel_idx = '0;
`ifdef ENCODER83_MSB_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (pend_q[i]) sel_idx = CODE_W'(i);
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend_q[i]) sel_idx = CODE_W'(i);
        end
`endif
        sel_mask = {{(WIDTH-1){1'b0}}, 1'b1} << sel_idx;
    end

    // Number of pending bits, which is also the beats still to be emitted.
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_cnt = pop_cnt + (CODE_W+1)'(pend_q[i]);
        end
    end

    // Outputs come only from registered state, en and the reset level.
    always_comb begin
        in_ready  = rst_n & en & (state_q == S_IDLE);
        out_valid = rst_n & en & (state_q == S_EMIT);
        out       = out_valid ? sel_idx : '0;
        out_last  = out_valid & (pop_cnt == (CODE_W+1)'(1));
        remaining = (rst_n && (state_q == S_EMIT)) ? pop_cnt : '0;
        zero_drop = zero_drop_q;
        accept    = in_valid & in_ready;
        beat      = out_valid & out_ready;
    end

    // Next-state: load a vector in IDLE, retire one bit per beat in EMIT.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        zero_drop_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (in != '0) begin
                        pend_d  = in;
                        state_d = S_EMIT;
                    end else begin
                        zero_drop_d = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (beat) begin
                    pend_d = pend_q & ~sel_mask;
                    if (out_last) state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                pend_d  = '0;
            end
        endcase
    end

    // State registers; reset discards any pending bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pend_q      <= '0;
            zero_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            zero_drop_q <= zero_drop_d;
        end
    end

endmodule

`default_nettype wire
